// File: rtl/gmii_frame_gen.sv
// GMII Ethernet II test-frame generator: preamble, SFD, MAC header, length, patterned
// payload with zero pad, CRC-32 FCS and IFG, in single, burst or continuous mode.
//
//  state | meaning
//  IDLE  | waiting for start, tx_en low
//  PRE   | 7 preamble bytes 8'h55
//  SFD   | start-of-frame delimiter 8'hD5
//  DST   | destination MAC, MSB byte first
//  SRC   | source MAC, MSB byte first
//  LEN   | length field, big-endian
//  PAY   | patterned payload then zero pad
//  FCS   | inverted CRC, LSB byte first
//  IFG   | inter-frame gap, tx_en low
module gmii_frame_gen #(
  parameter logic [47:0] DEST_MAC    = 48'h023528fbdd66,
  parameter logic [47:0] SRC_MAC     = 48'h072227acdb65,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          IFG_BYTES   = 12,
  parameter int          CNT_W       = 16
) (
  input  logic             eth_tx_clk,
  input  logic             eth_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [10:0]      payload_len,
  input  logic             pattern_sel,
  input  logic [7:0]       seed,
  input  logic             crc_err_inj,
  output logic [7:0]       gmii_tx_d,
  output logic             gmii_tx_en,
  output logic             gmii_tx_er,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_PAY, S_FCS, S_IFG
  } state_t;

  localparam logic [10:0] MAX_L   = 11'(MAX_PAYLOAD);
  localparam logic [10:0] MIN_L   = 11'(MIN_PAYLOAD);
  localparam logic [10:0] IFG_TC  = 11'(IFG_BYTES - 1);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  state_t           state_q, state_d;
  logic [10:0]      rem_q, rem_d;
  logic [10:0]      pay_idx_q, pay_idx_d;
  logic [CNT_W-1:0] burst_rem_q, burst_rem_d;
  logic [31:0]      crc_q, crc_d;
  logic             stop_q;
  logic [1:0]       mode_q;
  logic [10:0]      lc_q;
  logic             pat_q;
  logic [7:0]       seed_q;
  logic             inj_q;

  logic             last;
  logic             start_frame;
  logic             more_frames;
  logic [10:0]      lc_in;
  logic [10:0]      pay_total;
  logic [7:0]       byte_d;
  logic [31:0]      fcs;
  logic             en_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    return 8'(mac >> {idx, 3'b000});
  endfunction

  assign last       = (rem_q == 11'd0);
  assign lc_in      = (payload_len > MAX_L) ? MAX_L : payload_len;
  assign pay_total  = (lc_q < MIN_L) ? MIN_L : lc_q;
  assign fcs        = ~crc_q;
  assign gmii_tx_er = 1'b0;

  // a stop arriving on the very last IFG cycle still ends the run
  assign more_frames = !(stop_q || stop) &&
                       ((mode_q == 2'd2) || ((mode_q == 2'd1) && (burst_rem_q > CNT_W'(1))));

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pay_idx_d   = pay_idx_q;
    burst_rem_d = burst_rem_q;
    start_frame = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d     = S_PRE;
        rem_d       = 11'd6;
        start_frame = 1'b1;
        burst_rem_d = (burst_len == '0) ? CNT_W'(1) : burst_len;
      end
      S_PRE: if (last) state_d = S_SFD;
             else rem_d = rem_q - 1'b1;
      S_SFD: begin
        state_d = S_DST;
        rem_d   = 11'd5;
      end
      S_DST: if (last) begin
        state_d = S_SRC;
        rem_d   = 11'd5;
      end else rem_d = rem_q - 1'b1;
      S_SRC: if (last) begin
        state_d = S_LEN;
        rem_d   = 11'd1;
      end else rem_d = rem_q - 1'b1;
      S_LEN: if (last) begin
        state_d   = S_PAY;
        rem_d     = pay_total - 1'b1;
        pay_idx_d = 11'd0;
      end else rem_d = rem_q - 1'b1;
      S_PAY: if (last) begin
        state_d = S_FCS;
        rem_d   = 11'd3;
      end else begin
        rem_d     = rem_q - 1'b1;
        pay_idx_d = pay_idx_q + 1'b1;
      end
      S_FCS: if (last) begin
        state_d = S_IFG;
        rem_d   = IFG_TC;
      end else rem_d = rem_q - 1'b1;
      S_IFG: if (last) begin
        if (more_frames) begin
          state_d     = S_PRE;
          rem_d       = 11'd6;
          start_frame = 1'b1;
          burst_rem_d = burst_rem_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end else rem_d = rem_q - 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // next wire byte is derived from the next state so that outputs can be registered
  always_comb begin
    byte_d = 8'h00;
    case (state_d)
      S_PRE: byte_d = 8'h55;
      S_SFD: byte_d = 8'hD5;
      S_DST: byte_d = mac_byte(DEST_MAC, rem_d[2:0]);
      S_SRC: byte_d = mac_byte(SRC_MAC, rem_d[2:0]);
      S_LEN: byte_d = rem_d[0] ? {5'b0, lc_q[10:8]} : lc_q[7:0];
      S_PAY: if (pay_idx_d < lc_q) byte_d = pat_q ? seed_q : seed_q + pay_idx_d[7:0];
      S_FCS: begin
        byte_d = 8'(fcs >> {~rem_d[1:0], 3'b000});
        if (inj_q && rem_d[1:0] == 2'd3) byte_d[0] = ~byte_d[0];
      end
      default: byte_d = 8'h00;
    endcase
    en_d = (state_d != S_IDLE) && (state_d != S_IFG);
    crc_d = crc_q;
    if (start_frame)
      crc_d = 32'hFFFFFFFF;
    else if (state_d inside {S_DST, S_SRC, S_LEN, S_PAY})
      crc_d = crc_byte(crc_q, byte_d);
  end

  always_ff @(posedge eth_tx_clk) begin
    if (eth_rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      pay_idx_q   <= '0;
      burst_rem_q <= '0;
      crc_q       <= 32'hFFFFFFFF;
      stop_q      <= 1'b0;
      mode_q      <= '0;
      lc_q        <= '0;
      pat_q       <= 1'b0;
      seed_q      <= '0;
      inj_q       <= 1'b0;
      gmii_tx_d   <= '0;
      gmii_tx_en  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      pay_idx_q   <= pay_idx_d;
      burst_rem_q <= burst_rem_d;
      crc_q       <= crc_d;
      if (start_frame) begin
        mode_q <= mode;
        lc_q   <= lc_in;
        pat_q  <= pattern_sel;
        seed_q <= seed;
        inj_q  <= crc_err_inj;
      end
      // start together with stop in IDLE sends one frame, stop alone in IDLE is dropped
      if (state_q == S_IDLE)
        stop_q <= start & stop;
      else if (state_d == S_IDLE)
        stop_q <= 1'b0;
      else
        stop_q <= stop_q | stop;
      gmii_tx_d  <= byte_d;
      gmii_tx_en <= en_d;
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_q == S_FCS) && (state_d == S_IFG);
      if ((state_q == S_FCS) && (state_d == S_IFG))
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
